// File: rtl/online_div_sequencer_pkg.sv
// rtl/online_div_sequencer_pkg.sv - shared phase encodings and widths for the online divider
//
// Shared by the sequencer and the digit-register datapath so that both sides
// agree on the STATE encoding, the load-phase length and the counter widths.
package online_div_sequencer_pkg;

    // Phase encodings driven on STATE towards the datapath.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_LOAD  = 2'b10;
    localparam logic [1:0] ST_RECUR = 2'b11;
    localparam logic [1:0] ST_DONE  = 2'b01;

    // Zero-row load: one RAM word holding four 2-bit digits.
    localparam int LOAD_CYCLES_C = 4;

    // Digit counter and RAM word address widths.
    localparam int CNT_W  = 9;
    localparam int ADDR_W = 7;

endpackage

// File: rtl/online_div_sequencer.sv
// rtl/online_div_sequencer.sv - phase/counter sequencer for the online division datapath
//
// Ports:
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   start               division request, sampled in IDLE only
//   error_flag          datapath pipeline break; freezes all sequencing state
//   STATE               phase: 00 IDLE, 10 LOAD, 11 RECUR, 01 DONE
//   cnt                 digit counter
//   computation_cycles  current word index, cnt[8:2]
//   rd_addr             RAM word read address
//   digit_req           a new x/p digit is consumed this cycle
//   busy                STATE != IDLE
//   done                one-cycle completion pulse (DONE phase)
module online_div_sequencer
    import online_div_sequencer_pkg::*;
#(
    parameter int NUM_DIGITS  = 16,
    parameter int LOAD_CYCLES = LOAD_CYCLES_C
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              error_flag,
    output logic [1:0]        STATE,
    output logic [CNT_W-1:0]  cnt,
    output logic [ADDR_W-1:0] computation_cycles,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              digit_req,
    output logic              busy,
    output logic              done
);

    logic [1:0]        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              last_word;
    logic              stall;

    // An iteration at digit cnt reads words 0..cnt[8:2]; the last word ends it.
    assign last_word = (rd_addr_q == cnt_q[CNT_W-1:2]);

    // error_flag freezes every active phase; IDLE is unaffected so a start
    // can still be taken while the datapath reports a break.
    assign stall = error_flag && (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rd_addr_q <= '0;
        end else if (!stall) begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q     <= '0;
                    rd_addr_q <= '0;
                    if (start) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // cnt runs 0..LOAD_CYCLES-1 and lands on LOAD_CYCLES,
                    // which is exactly the first RECUR digit.
                    cnt_q     <= cnt_q + 1'b1;
                    rd_addr_q <= '0;
                    if (cnt_q == CNT_W'(LOAD_CYCLES - 1)) begin
                        state_q <= ST_RECUR;
                    end
                end
                ST_RECUR: begin
                    if (last_word) begin
                        rd_addr_q <= '0;
                        if (cnt_q == CNT_W'(NUM_DIGITS - 1)) begin
                            // Final digit: keep cnt so the datapath sees it in DONE.
                            state_q <= ST_DONE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        rd_addr_q <= rd_addr_q + 1'b1;
                    end
                end
                default: begin
                    // DONE: start is deliberately ignored here.
                    state_q   <= ST_IDLE;
                    cnt_q     <= '0;
                    rd_addr_q <= '0;
                end
            endcase
        end
    end

    assign STATE              = state_q;
    assign cnt                = cnt_q;
    assign computation_cycles = cnt_q[CNT_W-1:2];
    assign rd_addr            = rd_addr_q;
    assign busy               = (state_q != ST_IDLE);
    assign done               = (state_q == ST_DONE);

    // Every LOAD cycle consumes a digit; in RECUR only the first word of an
    // iteration does. A stalled cycle consumes nothing.
    assign digit_req = !error_flag &&
                       ((state_q == ST_LOAD) ||
                        ((state_q == ST_RECUR) && (rd_addr_q == '0)));

endmodule

// File: doc/online_div_sequencer.md
ONLINE_DIV_SEQUENCER -- requirements
Module: online_div_sequencer

Interface
REQ-001 Parameter NUM_DIGITS, default 16, total digit count per division (legal range 5..508).
REQ-002 Parameter LOAD_CYCLES, default 4, length of the zero-row load phase (fixed at 4; one RAM word of four 2-bit digits).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
REQ-004 Remaining ports SHALL be, one per line:
- start  in  1  division request, sampled in IDLE only
- error_flag  in  1  datapath pipeline break; freezes sequencing
- STATE  out  2  phase to datapath: 00 IDLE, 10 LOAD, 11 RECUR, 01 DONE
- cnt  out  9  digit counter
- computation_cycles  out  7  current word index, equal to cnt[8:2]
- rd_addr  out  7  RAM word read address
- digit_req  out  1  new x/p digit consumed this cycle
- busy  out  1  STATE != IDLE
- done  out  1  one-cycle completion pulse

Function
REQ-010 IDLE SHALL hold cnt=0, computation_cycles=0 and rd_addr=0; start=1 at an edge SHALL enter LOAD after that edge.
REQ-011 LOAD SHALL last exactly LOAD_CYCLES cycles, with cnt incrementing by 1 each cycle from 0 to 3, rd_addr=0 and digit_req=1 every cycle.
REQ-012 After the last LOAD cycle, the block SHALL enter RECUR with cnt=4 and rd_addr=0.
REQ-013 In RECUR, each digit iteration SHALL last computation_cycles+1 cycles, with rd_addr stepping 0,1,...,computation_cycles.
REQ-014 In RECUR, digit_req SHALL be 1 only when rd_addr==0.
REQ-015 On the last cycle of a RECUR iteration, the next edge SHALL increment cnt by 1 and reset rd_addr to 0; computation_cycles SHALL track cnt[8:2] combinationally from the registered cnt.
REQ-016 When the iteration with cnt==NUM_DIGITS-1 completes, the block SHALL enter DONE for exactly one cycle with done=1, then return to IDLE with cnt cleared.
REQ-017 While error_flag=1 in LOAD, RECUR or DONE, all registers SHALL hold and digit_req SHALL be 0; sequencing SHALL resume on the cycle after error_flag falls, with no digit lost or repeated.
REQ-018 Where error_flag=1 coincides with the last cycle of an iteration or phase, the stall SHALL take priority and no transition SHALL occur.
REQ-019 start SHALL be ignored while busy=1, including in the DONE cycle; a new division SHALL need start in IDLE.
REQ-020 cnt SHALL never wrap, because the NUM_DIGITS bound guarantees cnt<=507.
REQ-021 All outputs SHALL be registered or decoded from registered state only, with no combinational path from start or error_flag, except for the digit_req gating by error_flag.

Reset
REQ-030 Asserting rst_n=0 at any time, including mid-division, SHALL immediately force STATE=IDLE, cnt=0, rd_addr=0, done=0, busy=0 and digit_req=0.
REQ-031 After rst_n rises, the first start SHALL be honoured no earlier than the first rising clk edge.

Structure
REQ-040 State encodings (IDLE/LOAD/RECUR/DONE), LOAD_CYCLES, and the cnt (9) and address (7) widths SHALL live in a shared package also used by the digit-register datapath.
REQ-041 The block SHALL be one FSM plus the cnt and rd_addr counters, with no sub-module.

Verification
REQ-050 NUM_DIGITS=8, start pulsed once: SHALL give STATE 10 for 4 cycles (cnt 0..3), then 11 for 8 cycles (cnt 4,4,5,5,6,6,7,7 with rd_addr 0,1 alternating), then done=1 in cycle 13 after start accepted, then IDLE.
REQ-051 NUM_DIGITS=8, error_flag high for 3 cycles at cnt=5, rd_addr=1: SHALL freeze all outputs for 3 cycles and move done to cycle 16.
REQ-052 start held high throughout a division: SHALL give exactly one division, and a second SHALL begin only after STATE returns to 00.
REQ-053 rst_n pulsed low during RECUR (cnt=6): SHALL give all outputs zero asynchronously and no done pulse.
REQ-054 NUM_DIGITS=13: SHALL show the iteration at cnt=12 with rd_addr sweeping 0..3, digit_req pulsed once per iteration, and a total of 13 digit_req pulses.
REQ-055 error_flag asserted on the final RECUR cycle: SHALL hold STATE=11 until error_flag falls, then give DONE for one cycle.
